if_stage_fetch: RTL and testbench
=================================

// Module: if_stage_fetch
// PURPOSE
//   Instruction-fetch stage feeding id_stage: owns the PC, fetches from a
//   variable-latency instruction memory via req/ack, and drives the
//   registered IF/ID outputs (PC+4, instruction, valid).
//   Honours freeze (hazard stall) and branch redirect from EXE, including
//   redirects that arrive while a fetch is outstanding.
// PARAMETERS
//   ADDRESS_LEN      32  width of PC and memory address
//   INSTRUCTION_LEN  32  width of instruction word
//   RESET_PC         0   first fetch address after reset
// PORTS
//   clk             in   1                 clock, rising edge
//   rst             in   1                 asynchronous, active-low reset
//   freeze          in   1                 ID cannot accept; hold outputs
//   branch_taken    in   1                 one-cycle redirect pulse from EXE
//   branch_address  in   ADDRESS_LEN       redirect target
//   imem_req        out  1                 fetch request
//   imem_addr       out  ADDRESS_LEN       fetch address, stable while req=1 && ack=0
//   imem_ack        in   1                 rdata valid this cycle; may be same cycle as req
//   imem_rdata      in   INSTRUCTION_LEN   fetched word
//   pc_out          out  ADDRESS_LEN       fetched address + 4, to id_stage PC_in
//   instruction_out out  INSTRUCTION_LEN   to id_stage Instruction_in
//   valid_out       out  1                 outputs hold a real instruction
// BEHAVIOUR
// - Reset (rst=0): pc=RESET_PC, state=FETCH, buffer empty, pc_out=0,
//   instruction_out=0, valid_out=0; imem_req forced 0 while rst=0.
// - States: FETCH (req=1, addr=pc), DROP (req=1, addr=drop_addr, result
//   discarded), FULL (req=0, one fetched word parked in skid buffer).
// - ack is only sampled when req=1. All updates on rising clk edge.
// - Priority: branch_taken > freeze > normal.
// - FETCH, ack=1, freeze=0: instruction_out<=rdata, pc_out<=pc+4,
//   valid_out<=1, pc<=pc+4; stay FETCH. Zero-wait memory => 1 instr/cycle.
// - FETCH, ack=0, freeze=0: valid_out<=0 (bubble); pc held.
// - FETCH, freeze=1: outputs hold. If ack=1: buffer<={rdata,pc+4},
//   pc<=pc+4, go FULL. If ack=0: keep requesting, stay FETCH.
// - FULL, freeze=1: hold everything. FULL, freeze=0: outputs<=buffer,
//   valid_out<=1, buffer empty, go FETCH (req=1 next cycle).
// - branch_taken=1 (any state): pc<=branch_address, valid_out<=0,
//   instruction_out<=0, buffer emptied, freeze ignored this cycle.
//   From FETCH with ack=0: drop_addr<=pc (current addr), go DROP.
//   From FETCH with ack=1, or from FULL: go FETCH (word discarded).
//   From DROP: ack=1 -> FETCH; ack=0 -> stay DROP, drop_addr unchanged.
// - DROP, no branch: req held at drop_addr; on ack discard rdata, go FETCH
//   (imem_addr=pc=target next cycle); valid_out<=0 while in DROP, unless
//   freeze=1, in which case outputs hold (already invalid after flush).
// - PC arithmetic modulo 2^ADDRESS_LEN; 0xFFFFFFFC+4 wraps to 0.
// - Reset asserted mid-request: req drops immediately; any later ack ignored
//   until req re-issued at RESET_PC.
// - Never more than one outstanding request; imem_addr never changes while
//   req=1 && ack=0.
// TESTING
// 1 rst release, ack tied 1 -> addr 0,4,8 on cycles 1,2,3; pc_out 4,8,12
//   with valid_out=1 one cycle after each.
// 2 ack delayed 2 cycles per fetch -> imem_addr stable 3 cycles; valid_out
//   pattern 0,0,1 repeating; no instruction duplicated or lost.
// 3 freeze=1 for 3 cycles with ack=1 -> outputs frozen, req low after first
//   ack (FULL); freeze drop -> buffered word out, then next addr fetched.
// 4 branch_taken to 0x100 while addr 0x8 outstanding -> req stays at 0x8
//   until ack, word discarded, next req at 0x100; no valid_out for 0x8.
// 5 branch_taken with freeze=1 and ack=1 same cycle -> valid_out=0 next
//   cycle, next imem_addr=branch_address.
// 6 rst low during wait state -> all outputs zero, req=0 immediately;
//   after release first req at RESET_PC.

Source files
------------

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_fetch
// Description : Instruction-fetch stage that feeds id_stage. It owns the PC
//               and fetches from a variable-latency instruction memory over a
//               req/ack handshake. It drives the registered IF/ID outputs
//               (PC+4, instruction, valid) and handles freeze stalls and
//               branch redirects, including a redirect that arrives while a
//               fetch is still outstanding.
// Ports       : clk             - clock, rising edge
//               rst             - asynchronous, active-low reset
//               freeze          - ID cannot accept; hold outputs
//               branch_taken    - one-cycle redirect pulse from EXE
//               branch_address  - redirect target
//               imem_req        - fetch request
//               imem_addr       - fetch address, stable while req && !ack
//               imem_ack        - imem_rdata valid this cycle
//               imem_rdata      - fetched word
//               pc_out          - fetched address + 4
//               instruction_out - fetched instruction
//               valid_out       - outputs hold a real instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage_fetch #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0]     pc_out,
    output logic [INSTRUCTION_LEN-1:0] instruction_out,
    output logic                       valid_out
);

    localparam logic [ADDRESS_LEN-1:0] c_PC_STEP = ADDRESS_LEN'(4);

    // FETCH: requesting at r_pc.
    // DROP : a stale request (issued before a redirect) is still in flight;
    //        keep it stable at r_drop_addr and throw its data away.
    // FULL : one fetched word is parked in the skid buffer, no request.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_FULL  = 2'd2
    } fetch_state_t;

    fetch_state_t               r_state,     w_state_nxt;
    logic [ADDRESS_LEN-1:0]     r_pc,        w_pc_nxt;
    logic [ADDRESS_LEN-1:0]     r_drop_addr, w_drop_addr_nxt;
    logic [INSTRUCTION_LEN-1:0] r_buf_instr, w_buf_instr_nxt;
    logic [ADDRESS_LEN-1:0]     r_buf_pc,    w_buf_pc_nxt;
    logic [ADDRESS_LEN-1:0]     w_pc_out_nxt;
    logic [INSTRUCTION_LEN-1:0] w_instr_nxt;
    logic                       w_valid_nxt;
    logic [ADDRESS_LEN-1:0]     w_pc_plus4;
    logic                       w_ack;

    // Request is gated by reset directly so it drops the instant reset asserts.
    assign imem_req   = rst && (r_state != S_FULL);
    assign imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign w_ack      = imem_ack && imem_req;
    assign w_pc_plus4 = r_pc + c_PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_drop_addr     <= '0;
            r_buf_instr     <= '0;
            r_buf_pc        <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_drop_addr     <= w_drop_addr_nxt;
            r_buf_instr     <= w_buf_instr_nxt;
            r_buf_pc        <= w_buf_pc_nxt;
            pc_out          <= w_pc_out_nxt;
            instruction_out <= w_instr_nxt;
            valid_out       <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_pc_out_nxt    = pc_out;
        w_instr_nxt     = instruction_out;
        w_valid_nxt     = valid_out;

        if (branch_taken) begin
            // Redirect wins over freeze: flush outputs and skid buffer.
            w_pc_nxt    = branch_address;
            w_valid_nxt = 1'b0;
            w_instr_nxt = '0;
            case (r_state)
                S_FETCH: begin
                    if (!w_ack) begin
                        // The request at r_pc must complete before the
                        // target can be requested; remember it as stale.
                        w_drop_addr_nxt = r_pc;
                        w_state_nxt     = S_DROP;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (freeze) begin
                        if (w_ack) begin
                            w_buf_instr_nxt = imem_rdata;
                            w_buf_pc_nxt    = w_pc_plus4;
                            w_pc_nxt        = w_pc_plus4;
                            w_state_nxt     = S_FULL;
                        end
                    end else if (w_ack) begin
                        w_instr_nxt  = imem_rdata;
                        w_pc_out_nxt = w_pc_plus4;
                        w_valid_nxt  = 1'b1;
                        w_pc_nxt     = w_pc_plus4;
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end
                S_DROP: begin
                    if (!freeze) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (w_ack) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FULL: begin
                    if (!freeze) begin
                        w_instr_nxt  = r_buf_instr;
                        w_pc_out_nxt = r_buf_pc;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage_fetch
// Description : Self-checking bench for if_stage_fetch. Random freeze,
//               redirect and memory-ack traffic is compared every cycle
//               against a transaction-level model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int n_total = 0;
    int n_bad   = 0;

    if_stage_fetch #(
        .ADDRESS_LEN     (32),
        .INSTRUCTION_LEN (32),
        .RESET_PC        (32'h0)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    // ------------------------------------------------------------------
    // Reference model: PC, an optional stale in-flight request, a queue
    // of fetched-but-undelivered words, and the IF/ID output register.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] w;
        logic [31:0] p;
    } park_t;

    park_t       m_park[$];
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_pc_out;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_rst;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_park.delete();
        m_pc         = 32'h0;
        m_stale      = 1'b0;
        m_stale_addr = 32'h0;
        m_pc_out     = 32'h0;
        m_instr      = 32'h0;
        m_valid      = 1'b0;
        m_rst        = 1'b1;
    endtask

    function automatic logic exp_req();
        return !m_rst && (m_park.size() == 0);
    endfunction

    task automatic compare_outputs();
        logic [31:0] a;
        a = m_stale ? m_stale_addr : m_pc;
        check_val("valid_out", 32'(valid_out), 32'(m_valid));
        check_val("pc_out", pc_out, m_pc_out);
        check_val("instruction_out", instruction_out, m_instr);
        check_val("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) begin
            check_val("imem_addr", imem_addr, a);
        end
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        logic        req;
        logic        got;
        logic [31:0] a;
        park_t       p;
        req = (m_park.size() == 0);
        a   = m_stale ? m_stale_addr : m_pc;
        got = req && imem_ack;
        if (branch_taken) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_park.delete();
            if (m_stale) begin
                if (got) m_stale = 1'b0;
            end else if (req && !got) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_pc = branch_address;
        end else if (m_stale) begin
            if (!freeze) m_valid = 1'b0;
            if (got) m_stale = 1'b0;
        end else if (m_park.size() != 0) begin
            if (!freeze) begin
                p        = m_park.pop_front();
                m_instr  = p.w;
                m_pc_out = p.p;
                m_valid  = 1'b1;
            end
        end else if (got) begin
            if (freeze) begin
                p.w = mem_f(a);
                p.p = m_pc + 32'd4;
                m_park.push_back(p);
            end else begin
                m_instr  = mem_f(a);
                m_pc_out = m_pc + 32'd4;
                m_valid  = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!freeze) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFF8;
            2:       return 32'hFFFF_FFFC;
            default: return $urandom() & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic run_cycle(input int ack_pct, input int frz_pct, input int br_pct);
        @(negedge clk);
        compare_outputs();
        rst            = 1'b1;
        m_rst          = 1'b0;
        imem_ack       = ($urandom_range(0, 99) < ack_pct);
        freeze         = ($urandom_range(0, 99) < frz_pct);
        branch_taken   = ($urandom_range(0, 99) < br_pct);
        branch_address = pick_target();
        model_step();
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = $urandom_range(0, 1) == 1;
        model_reset();
        #1;
        compare_outputs();
    endtask

    initial begin
        rst            = 1'b1;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        imem_ack       = 1'b0;
        model_reset();
        #1 rst = 1'b0;

        repeat (3) reset_cycle();
        // Zero-wait memory streaming.
        repeat (30)  run_cycle(100, 0, 0);
        // Slow memory.
        repeat (200) run_cycle(30, 0, 0);
        // Stalls with fast memory (skid buffer use).
        repeat (200) run_cycle(100, 50, 0);
        // Redirects mixed with everything.
        repeat (400) run_cycle(50, 30, 10);
        repeat (400) run_cycle(20, 20, 20);
        repeat (300) run_cycle(100, 40, 15);
        // Park an outstanding request, then reset in the middle of it.
        repeat (4)   run_cycle(0, 0, 0);
        repeat (3)   reset_cycle();
        repeat (30)  run_cycle(100, 0, 0);
        repeat (400) run_cycle(40, 30, 15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
